reset_sequencer: RTL and testbench

- Parametrised successor to the single 2-flop negative-reset synchroniser.
- Asserts NUM_OUT active-low reset outputs asynchronously.
- Synchronises deassertion through a SYNC_STAGES-deep chain, then holds reset for a minimum HOLD_CYCLES.
- Releases the outputs one at a time, in index order, STAGGER_CYCLES apart; a synchronous software reset request re-runs the sequence. Sits at the top of the custom-logic clock domain and feeds per-subsystem resets.

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/reset_sync_chain.sv | 28 ++
 rtl/reset_sequencer.sv | 120 ++++++++++++
 tb/tb_reset_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the staggered reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD,
      RELEASE,
      RUN
   } reset_seq_state_t;

   // The hold and stagger phases share one counter, so it is sized for the longer of the two.
   function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
      int longest;
      longest = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
      return $clog2(longest) + 1;
   endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-deassert chain: shifts 1s in once reset_n is released.
module reset_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   output logic rst_sync
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], 1'b1};
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign rst_sync = chain_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator: synchronised release, minimum hold, then one output
// released every STAGGER_CYCLES in index order; sw_reset_req re-runs the sequence.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 16,
   parameter int NUM_OUT        = 4,
   parameter int STAGGER_CYCLES = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               sw_reset_req,
   output logic [NUM_OUT-1:0] reset_sync_n,
   output logic               reset_done
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
   localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   logic rst_sync;

   reset_seq_state_t   state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_OUT-1:0] reset_sync_n_q, reset_sync_n_d;
   logic               reset_done_q, reset_done_d;

   reset_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .rst_sync (rst_sync)
   );

   // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      reset_sync_n_d = reset_sync_n_q;
      reset_done_d   = reset_done_q;

      if (sw_reset_req) begin
         // The synchroniser is left alone: the restart only replays the hold and stagger phases.
         state_d        = HOLD;
         cnt_d          = '0;
         idx_d          = '0;
         reset_sync_n_d = '0;
         reset_done_d   = 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               if (!rst_sync) begin
                  cnt_d = '0;
               end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                  reset_sync_n_d[0] = 1'b1;
                  idx_d             = IDX_W'(1);
                  cnt_d             = '0;
                  if (NUM_OUT == 1) begin
                     state_d      = RUN;
                     reset_done_d = 1'b1;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            RELEASE: begin
               if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                  for (int k = 0; k < NUM_OUT; k++) begin
                     if (idx_q == IDX_W'(k)) begin
                        reset_sync_n_d[k] = 1'b1;
                     end
                  end
                  idx_d = idx_q + IDX_W'(1);
                  cnt_d = '0;
                  if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                     state_d      = RUN;
                     reset_done_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            RUN: begin
               reset_sync_n_d = '1;
            end

            default: begin
               state_d = HOLD;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= HOLD;
         cnt_q          <= '0;
         idx_q          <= '0;
         reset_sync_n_q <= '0;
         reset_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         reset_sync_n_q <= reset_sync_n_d;
         reset_done_q   <= reset_done_d;
      end
   end

   assign reset_sync_n = reset_sync_n_q;
   assign reset_done   = reset_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a corner-parameter instance.
module tb_reset_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       sw_reset_req;
   logic [3:0] out_n;
   logic       done;

   logic       reset_n_c;
   logic       sw_reset_req_c;
   logic [0:0] out_n_c;
   logic       done_c;

   int n_cmp  = 0;
   int n_fail = 0;
   int ecnt   = 0;

   typedef struct {
      int         upto;
      logic       sw;
      logic [3:0] exp_out;
      logic       exp_done;
   } vec_t;

   vec_t vecs [16];

   always #5 clock = ~clock;

   reset_sequencer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .sw_reset_req (sw_reset_req),
      .reset_sync_n (out_n),
      .reset_done   (done)
   );

   reset_sequencer #(
      .SYNC_STAGES    (3),
      .HOLD_CYCLES    (1),
      .NUM_OUT        (1),
      .STAGGER_CYCLES (4)
   ) dut_c (
      .clock        (clock),
      .reset_n      (reset_n_c),
      .sw_reset_req (sw_reset_req_c),
      .reset_sync_n (out_n_c),
      .reset_done   (done_c)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One rising edge, then sample; ordering and done invariants are checked on every edge.
   task automatic step();
      logic bad;
      @(posedge clock);
      #1;
      ecnt++;
      bad = 1'b0;
      for (int k = 1; k < 4; k++) begin
         if (out_n[k] && !out_n[k-1]) bad = 1'b1;
      end
      check($sformatf("order@%0d", ecnt), {31'd0, bad}, 32'd0);
      if (done) check($sformatf("done_all@%0d", ecnt), {28'd0, out_n}, 32'hF);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
      ecnt    = 0;
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         sw_reset_req = vecs[i].sw;
         while (ecnt < vecs[i].upto) step();
         check($sformatf("vec%0d@%0d", i, ecnt), {27'd0, out_n, done},
               {27'd0, vecs[i].exp_out, vecs[i].exp_done});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int f_edge;

      // Power-up sequence, then a one-cycle software request at edge 100.
      vecs[0]  = '{1,   1'b0, 4'h0, 1'b0};
      vecs[1]  = '{17,  1'b0, 4'h0, 1'b0};
      vecs[2]  = '{18,  1'b0, 4'h1, 1'b0};
      vecs[3]  = '{21,  1'b0, 4'h1, 1'b0};
      vecs[4]  = '{22,  1'b0, 4'h3, 1'b0};
      vecs[5]  = '{25,  1'b0, 4'h3, 1'b0};
      vecs[6]  = '{26,  1'b0, 4'h7, 1'b0};
      vecs[7]  = '{29,  1'b0, 4'h7, 1'b0};
      vecs[8]  = '{30,  1'b0, 4'hF, 1'b1};
      vecs[9]  = '{40,  1'b0, 4'hF, 1'b1};
      vecs[10] = '{99,  1'b0, 4'hF, 1'b1};
      vecs[11] = '{100, 1'b1, 4'h0, 1'b0};
      vecs[12] = '{115, 1'b0, 4'h0, 1'b0};
      vecs[13] = '{116, 1'b0, 4'h1, 1'b0};
      vecs[14] = '{127, 1'b0, 4'h7, 1'b0};
      vecs[15] = '{128, 1'b0, 4'hF, 1'b1};

      reset_n        = 1'b0;
      sw_reset_req   = 1'b0;
      reset_n_c      = 1'b0;
      sw_reset_req_c = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      check("reset_state", {27'd0, out_n, done}, 32'd0);

      release_reset();
      run_vectors(0, 15);

      // Async assertion mid-cycle while in RUN clears before the next edge.
      #3;
      reset_n = 1'b0;
      #1;
      check("async_clear", {27'd0, out_n, done}, 32'd0);
      @(posedge clock);
      release_reset();
      run_vectors(0, 9);

      // Software request mid-RELEASE at edge 24.
      #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      release_reset();
      while (ecnt < 23) step();
      check("mid_pre", {27'd0, out_n, done}, {27'd0, 4'h3, 1'b0});
      sw_reset_req = 1'b1;
      step();
      sw_reset_req = 1'b0;
      check("mid_clear@24", {27'd0, out_n, done}, 32'd0);
      while (ecnt < 39) step();
      check("mid_out0@39", {27'd0, out_n, done}, 32'd0);
      step();
      check("mid_out0@40", {27'd0, out_n, done}, {27'd0, 4'h1, 1'b0});

      // Held request for 50 edges; F is the last edge that samples it high.
      sw_reset_req = 1'b1;
      repeat (50) begin
         step();
         check($sformatf("held@%0d", ecnt), {27'd0, out_n, done}, 32'd0);
      end
      f_edge       = ecnt;
      sw_reset_req = 1'b0;
      while (ecnt < f_edge + 15) step();
      check("held_F+15", {27'd0, out_n, done}, 32'd0);
      step();
      check("held_F+16", {27'd0, out_n, done}, {27'd0, 4'h1, 1'b0});

      // Corner instance: NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=3.
      @(negedge clock);
      reset_n_c = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("corner@3", {30'd0, out_n_c, done_c}, 32'd0);
      @(posedge clock);
      #1;
      check("corner@4", {30'd0, out_n_c, done_c}, 32'd3);
      #2;
      reset_n_c = 1'b0;
      #1;
      reset_n_c = 1'b1;
      #1;
      check("corner_glitch", {30'd0, out_n_c, done_c}, 32'd0);
      repeat (3) @(posedge clock);
      #1;
      check("corner_re@3", {30'd0, out_n_c, done_c}, 32'd0);
      @(posedge clock);
      #1;
      check("corner_re@4", {30'd0, out_n_c, done_c}, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
